csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR file. It is the responder on the commit-stage CSR write interface (csr_wif.rsp).
- It also serves a combinational read port to the dispatcher; that read supplies csr_rdata in the register-file stage.
- It holds trap-entry state: mepc, mcause and mstatus.MIE/MPIE.
- It provides mtvec and mepc to the system unit for trap and mret redirection.
- It keeps 64-bit mcycle and minstret counters.

Parameters:
- HART_ID, 0: value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- MISA_VALUE, 32'h4000_0100: read-only misa value (RV32I).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous and active-high.
- wbcsr_wif  csr_wif.rsp  -  write request from the committer.
  - Fields: addr[11:0], data[XLEN], pc[XLEN], cause[XLEN], trap, valid.
- rd_addr  input  12  CSR read address from the dispatcher.
- rd_data  output  XLEN  read data.
- rd_illegal  output  1  rd_addr is not implemented.
- retire  input  1  one instruction committed this cycle.
- mret  input  1  mret committed this cycle.
- mtvec_o  output  XLEN  current mtvec, with bits[1:0] equal to 0.
- mepc_o  output  XLEN  current mepc.
- mie_o  output  1  mstatus.MIE.

Behaviour:
- Implemented CSRs:
  - mstatus (0x300): only MIE (bit 3) and MPIE (bit 7) are stored; MPP reads as 2'b11; all other bits read 0.
  - misa (0x301): read-only.
  - mtvec (0x305): direct mode only; bits[1:0] are forced to 0 on write.
  - mscratch (0x340): full XLEN.
  - mepc (0x341): bits[1:0] are forced to 0.
  - mcause (0x342): full XLEN.
  - mtval (0x343): full XLEN.
  - mcycle/mcycleh (0xB00/0xB80).
  - minstret/minstreth (0xB02/0xB82).
  - cycle/cycleh and instret/instreth (0xC00/0xC80/0xC02/0xC82): read-only aliases.
  - mhartid (0xF14): read-only.
- Reset values (asynchronous):
  - mstatus.MIE = 0, mstatus.MPIE = 0.
  - mtvec = MTVEC_RESET.
  - mscratch, mepc, mcause, mtval = 0.
  - Both counters = 0.
  - Outputs follow from these register values.
- Read port:
  - Purely combinational from rd_addr.
  - An unimplemented address gives rd_data = 0 and rd_illegal = 1.
  - There is no write-to-read bypass: a read in the same cycle as a write returns the old value, and the new value is visible the next cycle.
- Write, effective at the clock edge when wbcsr_wif.valid = 1 and trap = 0:
  - data is written to the CSR at addr, with WARL masking applied.
  - Writes to read-only or unimplemented addresses are silently dropped.
- Trap, when valid = 1 and trap = 1:
  - mepc <= pc & ~3.
  - mcause <= cause.
  - MPIE <= MIE.
  - MIE <= 0.
  - mtval <= 0.
  - The addr/data write is ignored.
- mret: MIE <= MPIE and MPIE <= 1.
- Simultaneous trap and mret: the trap wins and mret is ignored.
- Simultaneous mret and a non-trap mstatus write: mret wins for MIE/MPIE.
- mcycle:
  - Increments by 1 every cycle after reset deassertion.
  - A software write to the low or high half replaces that half, and no increment occurs in that cycle.
  - The 32-bit low-to-high carry wraps naturally: 0xFFFF_FFFF_FFFF_FFFF goes to 0.
- minstret:
  - Increments by 1 when retire = 1.
  - A same-cycle write wins and the retire increment is dropped. The CSR write instruction itself is therefore not counted.
- Latency: one cycle from write to visibility on all outputs.
- Reset asserted mid-operation: all state returns to reset values immediately, and an in-flight write is lost.

Decomposition:
- riscv_pkg holds:
  - CSR address constants (CSR_MSTATUS, CSR_MTVEC, ...).
  - mstatus bit indices (MSTATUS_MIE = 3, MSTATUS_MPIE = 7).
  - The XLEN constant.
- offnariscv_pkg holds the misa default.
- One sub-module: csr_counter64.
  - Ports: clk, rst, inc, wr_lo, wr_hi, wdata[31:0], value[63:0].
  - Instantiated twice, once for mcycle and once for minstret.

Test Plan:
- Reset then read:
  - mtvec → MTVEC_RESET.
  - mhartid → 0.
  - misa → 0x4000_0100.
  - rd_addr 0x7C0 → rd_data = 0 and rd_illegal = 1.
- Write mtvec = 0x8000_0103 → next cycle mtvec_o = 0x8000_0100. A same-cycle read returns the old value.
- With MIE = 1, trap with pc = 0x0000_1236 and cause = 0x0000_000B → mepc = 0x0000_1234, mcause = 0xB, MIE = 0, MPIE = 1. A following mret → MIE = 1, MPIE = 1.
- Trap and mret in the same cycle with MIE = 1 → MIE = 0 and MPIE = 1; mret has no effect.
- Write mcycle = 0xFFFF_FFFF and mcycleh = 0 → after one more cycle mcycleh reads 1 and mcycle reads 0.
- Assert retire for 5 cycles with a minstret write of 100 on the third cycle → final minstret = 102.

Source files
------------

// File: rtl/offnariscv_pkg.sv
// Core-specific defaults for the offnariscv implementation.
package offnariscv_pkg;

  // RV32I: MXL=1, I extension bit set.
  localparam logic [31:0] MISA_DEFAULT = 32'h4000_0100;

endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: XLEN, machine-mode CSR addresses and mstatus layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  localparam logic [XLEN-1:0] WORD_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
  function automatic logic [XLEN-1:0] mstatus_pack(mstatus_t s);
    logic [XLEN-1:0] v;
    v = '0;
    v[12:11]      = MSTATUS_MPP_M;
    v[MSTATUS_MIE]  = s.mie;
    v[MSTATUS_MPIE] = s.mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_wif.sv
// Commit-stage CSR write / trap request bundle.
interface csr_wif;
  logic [11:0]                 addr;
  logic [riscv_pkg::XLEN-1:0]  data;
  logic [riscv_pkg::XLEN-1:0]  pc;
  logic [riscv_pkg::XLEN-1:0]  cause;
  logic                        trap;
  logic                        valid;

  modport req (output addr, data, pc, cause, trap, valid);
  modport rsp (input  addr, data, pc, cause, trap, valid);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] r_value;

  // A software write to either half suppresses that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (wr_lo) begin
      r_value[31:0] <= wdata;
    end else if (wr_hi) begin
      r_value[63:32] <= wdata;
    end else if (inc) begin
      r_value <= r_value + 64'd1;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: commit-stage writes and traps, combinational dispatcher read,
// trap/mret state and 64-bit mcycle/minstret counters.
module csr_file
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [XLEN-1:0] MISA_VALUE  = offnariscv_pkg::MISA_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  csr_wif.rsp             wbcsr_wif,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic            retire,
  input  logic            mret,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  mstatus_t        r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic            w_trap;
  logic            w_wr;
  logic [63:0]     w_mcycle;
  logic [63:0]     w_minstret;
  logic [XLEN-1:0] w_rd_data;
  logic            w_rd_illegal;

  assign w_trap = wbcsr_wif.valid & wbcsr_wif.trap;
  assign w_wr   = wbcsr_wif.valid & ~wbcsr_wif.trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus  <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (w_trap) begin
      // Trap entry overrides both the CSR write and any concurrent mret.
      r_mepc         <= wbcsr_wif.pc & WORD_ALIGN_MASK;
      r_mcause       <= wbcsr_wif.cause;
      r_mstatus.mpie <= r_mstatus.mie;
      r_mstatus.mie  <= 1'b0;
      r_mtval        <= '0;
    end else begin
      if (mret) begin
        r_mstatus.mie  <= r_mstatus.mpie;
        r_mstatus.mpie <= 1'b1;
      end else if (w_wr && wbcsr_wif.addr == CSR_MSTATUS) begin
        r_mstatus.mie  <= wbcsr_wif.data[MSTATUS_MIE];
        r_mstatus.mpie <= wbcsr_wif.data[MSTATUS_MPIE];
      end
      if (w_wr) begin
        case (wbcsr_wif.addr)
          CSR_MTVEC:    r_mtvec    <= wbcsr_wif.data & WORD_ALIGN_MASK;
          CSR_MSCRATCH: r_mscratch <= wbcsr_wif.data;
          CSR_MEPC:     r_mepc     <= wbcsr_wif.data & WORD_ALIGN_MASK;
          CSR_MCAUSE:   r_mcause   <= wbcsr_wif.data;
          CSR_MTVAL:    r_mtval    <= wbcsr_wif.data;
          default:      ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (w_wr && wbcsr_wif.addr == CSR_MCYCLE),
    .wr_hi (w_wr && wbcsr_wif.addr == CSR_MCYCLEH),
    .wdata (wbcsr_wif.data),
    .value (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (w_wr && wbcsr_wif.addr == CSR_MINSTRET),
    .wr_hi (w_wr && wbcsr_wif.addr == CSR_MINSTRETH),
    .wdata (wbcsr_wif.data),
    .value (w_minstret)
  );

  // Read port sees only registered state, so a same-cycle write is not forwarded.
  always_comb begin
    w_rd_data    = '0;
    w_rd_illegal = 1'b0;
    case (rd_addr)
      CSR_MSTATUS:                 w_rd_data = mstatus_pack(r_mstatus);
      CSR_MISA:                    w_rd_data = MISA_VALUE;
      CSR_MTVEC:                   w_rd_data = r_mtvec;
      CSR_MSCRATCH:                w_rd_data = r_mscratch;
      CSR_MEPC:                    w_rd_data = r_mepc;
      CSR_MCAUSE:                  w_rd_data = r_mcause;
      CSR_MTVAL:                   w_rd_data = r_mtval;
      CSR_MCYCLE,   CSR_CYCLE:     w_rd_data = w_mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    w_rd_data = w_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   w_rd_data = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rd_data = w_minstret[63:32];
      CSR_MHARTID:                 w_rd_data = HART_ID;
      default:                     w_rd_illegal = 1'b1;
    endcase
  end

  assign rd_data    = w_rd_data;
  assign rd_illegal = w_rd_illegal;
  assign mtvec_o    = r_mtvec;
  assign mepc_o     = r_mepc;
  assign mie_o      = r_mstatus.mie;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against a reference model.
module tb_csr_file;

  localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic        retire;
  logic        mret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int n_checks = 0;
  int n_fail   = 0;

  csr_wif wif ();

  csr_file #(.MTVEC_RESET(TB_MTVEC_RESET)) dut (
    .clk        (clk),
    .rst        (rst),
    .wbcsr_wif  (wif),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_illegal (rd_illegal),
    .retire     (retire),
    .mret       (mret),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o),
    .mie_o      (mie_o)
  );

  always #5 clk = ~clk;

  // Reference model: architectural CSR state updated from the rules, counters as plain 64-bit numbers.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mie <= 0; m_mpie <= 0; m_mtvec <= TB_MTVEC_RESET;
      m_mscratch <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
      m_cyc <= 0; m_ins <= 0;
    end else begin
      if (wif.valid && wif.trap) begin
        m_mepc   <= wif.pc - (wif.pc % 4);
        m_mcause <= wif.cause;
        m_mpie   <= m_mie;
        m_mie    <= 0;
        m_mtval  <= 0;
      end else begin
        if (mret) begin
          m_mie <= m_mpie; m_mpie <= 1;
        end else if (wif.valid && wif.addr == 12'h300) begin
          m_mie <= (wif.data / 8) % 2; m_mpie <= (wif.data / 128) % 2;
        end
        if (wif.valid) begin
          if (wif.addr == 12'h305) m_mtvec    <= wif.data - (wif.data % 4);
          if (wif.addr == 12'h340) m_mscratch <= wif.data;
          if (wif.addr == 12'h341) m_mepc     <= wif.data - (wif.data % 4);
          if (wif.addr == 12'h342) m_mcause   <= wif.data;
          if (wif.addr == 12'h343) m_mtval    <= wif.data;
        end
      end
      if (wif.valid && !wif.trap && wif.addr == 12'hB00)      m_cyc <= (m_cyc / 64'h1_0000_0000) * 64'h1_0000_0000 + wif.data;
      else if (wif.valid && !wif.trap && wif.addr == 12'hB80) m_cyc <= {wif.data, 32'h0} + (m_cyc % 64'h1_0000_0000);
      else                                                    m_cyc <= m_cyc + 1;
      if (wif.valid && !wif.trap && wif.addr == 12'hB02)      m_ins <= (m_ins / 64'h1_0000_0000) * 64'h1_0000_0000 + wif.data;
      else if (wif.valid && !wif.trap && wif.addr == 12'hB82) m_ins <= {wif.data, 32'h0} + (m_ins % 64'h1_0000_0000);
      else if (retire)                                        m_ins <= m_ins + 1;
    end
  end

  // Returns {illegal, data} for a read of address a under the model state.
  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0)};
      12'h301: return {1'b0, 32'h4000_0100};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h343: return {1'b0, m_mtval};
      12'hB00, 12'hC00: return {1'b0, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_ins[63:32]};
      12'hF14: return {1'b0, 32'h0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic idle_inputs();
    wif.valid = 0; wif.trap = 0; wif.addr = 0; wif.data = 0;
    wif.pc = 0; wif.cause = 0; retire = 0; mret = 0;
  endtask

  // Called just after a falling edge; returns just after the next one with inputs idle.
  task automatic write_csr(input logic [11:0] a, input logic [31:0] d);
    wif.valid = 1; wif.addr = a; wif.data = d;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); rd_addr = 12'h305;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    n_checks++; if (rd_data !== TB_MTVEC_RESET) begin n_fail++; $display("FAIL reset_mtvec got %h want %h", rd_data, TB_MTVEC_RESET); end
    n_checks++; if ({mtvec_o, mepc_o, mie_o} !== {TB_MTVEC_RESET, 32'h0, 1'b0}) begin n_fail++; $display("FAIL reset_outputs got %h/%h/%b", mtvec_o, mepc_o, mie_o); end
    rd_addr = 12'hF14; #1;
    n_checks++; if ({rd_illegal, rd_data} !== 33'h0) begin n_fail++; $display("FAIL reset_mhartid got %b/%h want 0/0", rd_illegal, rd_data); end
    rd_addr = 12'h301; #1;
    n_checks++; if (rd_data !== 32'h4000_0100) begin n_fail++; $display("FAIL reset_misa got %h want 40000100", rd_data); end
    rd_addr = 12'h7C0; #1;
    n_checks++; if ({rd_illegal, rd_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL reset_illegal got %b/%h want 1/0", rd_illegal, rd_data); end
    @(negedge clk);
    rd_addr = 12'hB00; #1;
    n_checks++; if (rd_data !== 32'd1) begin n_fail++; $display("FAIL reset_mcycle_first got %0d want 1", rd_data); end
    rd_addr = 12'h300; #1;
    n_checks++; if (rd_data !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus got %h want 1800", rd_data); end
    @(negedge clk);
  endtask

  task automatic test_mtvec_write();
    wif.valid = 1; wif.addr = 12'h305; wif.data = 32'h8000_0103; rd_addr = 12'h305;
    #1;
    n_checks++; if (rd_data !== TB_MTVEC_RESET) begin n_fail++; $display("FAIL mtvec_no_bypass got %h want %h", rd_data, TB_MTVEC_RESET); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (mtvec_o !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_o got %h want 80000100", mtvec_o); end
    n_checks++; if (rd_data !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_read got %h want 80000100", rd_data); end
    @(negedge clk);
  endtask

  task automatic test_trap_mret();
    write_csr(12'h343, 32'h55);
    write_csr(12'h300, 32'h8);
    wif.valid = 1; wif.trap = 1; wif.pc = 32'h1236; wif.cause = 32'hB;
    wif.addr = 12'h340; wif.data = 32'hDEAD_BEEF;
    @(negedge clk); idle_inputs();
    rd_addr = 12'h342; #1;
    n_checks++; if ({mepc_o, mie_o} !== {32'h1234, 1'b0}) begin n_fail++; $display("FAIL trap_mepc_mie got %h/%b want 1234/0", mepc_o, mie_o); end
    n_checks++; if (rd_data !== 32'hB) begin n_fail++; $display("FAIL trap_mcause got %h want b", rd_data); end
    rd_addr = 12'h300; #1;
    n_checks++; if (rd_data !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus got %h want 1880", rd_data); end
    rd_addr = 12'h340; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL trap_write_ignored got %h want 0", rd_data); end
    rd_addr = 12'h343; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL trap_mtval got %h want 0", rd_data); end
    @(negedge clk);
    mret = 1;
    @(negedge clk); idle_inputs();
    rd_addr = 12'h300; #1;
    n_checks++; if ({mie_o, rd_data} !== {1'b1, 32'h1888}) begin n_fail++; $display("FAIL mret_mstatus got %b/%h want 1/1888", mie_o, rd_data); end
    @(negedge clk);
  endtask

  task automatic test_trap_mret_same();
    wif.valid = 1; wif.trap = 1; wif.pc = 32'h2000; wif.cause = 32'h3; mret = 1;
    @(negedge clk); idle_inputs();
    rd_addr = 12'h300; #1;
    n_checks++; if ({mie_o, rd_data, mepc_o} !== {1'b0, 32'h1880, 32'h2000}) begin n_fail++; $display("FAIL trap_beats_mret got %b/%h/%h want 0/1880/2000", mie_o, rd_data, mepc_o); end
    @(negedge clk);
    mret = 1; wif.valid = 1; wif.addr = 12'h300; wif.data = 32'h0;
    @(negedge clk); idle_inputs();
    rd_addr = 12'h300; #1;
    n_checks++; if ({mie_o, rd_data} !== {1'b1, 32'h1888}) begin n_fail++; $display("FAIL mret_beats_write got %b/%h want 1/1888", mie_o, rd_data); end
    @(negedge clk);
  endtask

  task automatic test_mcycle_wrap();
    write_csr(12'hB00, 32'hFFFF_FFFF);
    write_csr(12'hB80, 32'h0);
    @(negedge clk);
    rd_addr = 12'hB80; #1;
    n_checks++; if (rd_data !== 32'd1) begin n_fail++; $display("FAIL mcycle_carry_hi got %h want 1", rd_data); end
    rd_addr = 12'hB00; #1;
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL mcycle_carry_lo got %h want 0", rd_data); end
    @(negedge clk);
    write_csr(12'hB00, 32'hFFFF_FFFF);
    write_csr(12'hB80, 32'hFFFF_FFFF);
    rd_addr = 12'hC80; #1;
    n_checks++; if (rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycleh_alias got %h want ffffffff", rd_data); end
    @(negedge clk);
    rd_addr = 12'hB00; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_lo got %h want 0", rd_data); end
    rd_addr = 12'hB80; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_hi got %h want 0", rd_data); end
    @(negedge clk);
  endtask

  task automatic test_minstret();
    for (int i = 0; i < 5; i++) begin
      retire = 1;
      wif.valid = (i == 2); wif.addr = 12'hB02; wif.data = 32'd100;
      @(negedge clk);
    end
    idle_inputs();
    rd_addr = 12'hB02; #1;
    n_checks++; if (rd_data !== 32'd102) begin n_fail++; $display("FAIL minstret got %0d want 102", rd_data); end
    rd_addr = 12'hC02; #1;
    n_checks++; if (rd_data !== 32'd102) begin n_fail++; $display("FAIL instret_alias got %0d want 102", rd_data); end
    rd_addr = 12'hB82; #1;
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL minstreth got %h want 0", rd_data); end
    @(negedge clk);
  endtask

  task automatic test_readonly();
    write_csr(12'h301, 32'h0);
    write_csr(12'hF14, 32'h5);
    write_csr(12'h7C0, 32'h1234);
    rd_addr = 12'h301; #1;
    n_checks++; if (rd_data !== 32'h4000_0100) begin n_fail++; $display("FAIL misa_ro got %h want 40000100", rd_data); end
    rd_addr = 12'hF14; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mhartid_ro got %h want 0", rd_data); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [11:0] addrs [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                12'hC82, 12'hF14, 12'h7C0, 12'h344};
    logic [32:0] exp;
    for (int i = 0; i < 400; i++) begin
      wif.valid = ($urandom % 2) == 0;
      wif.trap  = ($urandom % 6) == 0;
      wif.addr  = addrs[$urandom % 18];
      wif.data  = $urandom;
      wif.pc    = $urandom;
      wif.cause = $urandom;
      retire    = ($urandom % 2) == 0;
      mret      = ($urandom % 5) == 0;
      rd_addr   = addrs[$urandom % 18];
      #1;
      exp = model_read(rd_addr);
      n_checks++; if ({rd_illegal, rd_data} !== exp) begin n_fail++; $display("FAIL rand_read[%0d] addr %h got %b/%h want %b/%h", i, rd_addr, rd_illegal, rd_data, exp[32], exp[31:0]); end
      n_checks++; if ({mtvec_o, mepc_o, mie_o} !== {m_mtvec, m_mepc, m_mie}) begin n_fail++; $display("FAIL rand_outputs[%0d] got %h/%h/%b want %h/%h/%b", i, mtvec_o, mepc_o, mie_o, m_mtvec, m_mepc, m_mie); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    write_csr(12'h340, 32'h1111_1111);
    wif.valid = 1; wif.addr = 12'h340; wif.data = 32'h2222_2222;
    #2 rst = 1;
    @(negedge clk);
    idle_inputs(); rst = 0;
    rd_addr = 12'h340; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midop_mscratch got %h want 0", rd_data); end
    n_checks++; if ({mtvec_o, mepc_o, mie_o} !== {TB_MTVEC_RESET, 32'h0, 1'b0}) begin n_fail++; $display("FAIL midop_outputs got %h/%h/%b", mtvec_o, mepc_o, mie_o); end
    rd_addr = 12'hB00; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midop_mcycle got %h want 0", rd_data); end
    rd_addr = 12'hB02; #1;
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midop_minstret got %h want 0", rd_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mtvec_write();
    test_trap_mret();
    test_trap_mret_same();
    test_mcycle_wrap();
    test_minstret();
    test_readonly();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
